// File: rtl/uart_pkg.sv
// Shared types and constants for the register-mapped UART receiver.
// Contents: FSM state enum, register-bus select/address codes, status bit
// indices, field widths and the clocks-per-bit rounding helper.
package uart_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;

  localparam logic REG_CTRL  = 1'b0;
  localparam logic REG_DATA  = 1'b1;
  localparam logic ADDR_BYTE = 1'b0;
  localparam logic ADDR_CNT  = 1'b1;

  localparam int unsigned ST_NEW  = 0;
  localparam int unsigned ST_OVR  = 1;
  localparam int unsigned ST_FERR = 2;

  localparam int unsigned STATUS_W = 3;
  localparam int unsigned BUS_W    = 32;
  localparam int unsigned BYTE_W   = 8;
  localparam int unsigned FCNT_W   = 16;

  // Clocks per bit rounded to nearest.
  function automatic int unsigned clk_per_bit(input int unsigned freq, input int unsigned baud);
    return (freq + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_rx_periph_if.sv
// Register bus between the test generator (master) and the UART receiver (slave).
// Signals: wr_i write strobe, reg_sel_i ctrl/data select, addr_i data index,
// entrada_i write data, salida_o read data (combinational in the slave).
interface uart_rx_periph_if;
  logic        wr_i;
  logic        reg_sel_i;
  logic        addr_i;
  logic [31:0] entrada_i;
  logic [31:0] salida_o;

  modport master (output wr_i, output reg_sel_i, output addr_i, output entrada_i, input salida_o);
  modport slave  (input wr_i, input reg_sel_i, input addr_i, input entrada_i, output salida_o);
endinterface

// File: rtl/uart_rx_core.sv
// 8N1 LSB-first UART deserialiser: 2-FF synchroniser plus receive FSM.
// Ports: clk, rst (sync active-high), rx (async serial line, idle high),
// byte_o (assembled byte), valid_o (1-cycle pulse on a good stop bit),
// ferr_o (1-cycle pulse on a low stop bit). The pulses are asserted in the
// cycle whose edge samples the stop bit, so the register bank updates on that edge.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int unsigned CLK_PER_BIT = 1042
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx,
  output logic [BYTE_W-1:0] byte_o,
  output logic              valid_o,
  output logic              ferr_o
);

  localparam int unsigned CNT_W = $clog2(CLK_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLK_PER_BIT - 1);

  logic              rx_meta, rx_s;
  rx_state_t         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [BYTE_W-1:0] shreg_q, shreg_d;

  // Synchroniser, reset to the idle (high) line level.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shreg_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shreg_q   <= shreg_d;
    end
  end

  // Next-state logic; START checks mid-bit to reject short glitches.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shreg_d   = shreg_q;
    valid_o   = 1'b0;
    ferr_o    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = rx_s ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d            = '0;
          shreg_d[bit_idx_q] = rx_s;
          if (bit_idx_q == 3'd7) state_d = STOP;
          else bit_idx_d = bit_idx_q + 3'd1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          valid_o = rx_s;
          ferr_o  = !rx_s;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign byte_o = shreg_q;

endmodule

// File: rtl/uart_rx_periph.sv
// Register-mapped UART receiver on the test-generator register bus.
// Ports: clk, rst (sync active-high), bus (slave modport: wr_i, reg_sel_i,
// addr_i, entrada_i, salida_o), rx (async serial input, idle high).
// Read map: ctrl = {frame_err, overrun, new_rx}; data0 = last good byte;
// data1 = 16-bit good-frame count. Flags are sticky until software writes them.
module uart_rx_periph
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 10_000_000,
  parameter int unsigned BAUD     = 9600
) (
  input  logic            clk,
  input  logic            rst,
  uart_rx_periph_if.slave bus,
  input  logic            rx
);

  localparam int unsigned CLK_PER_BIT = clk_per_bit(CLK_FREQ, BAUD);

  logic [BYTE_W-1:0]   core_byte;
  logic                core_valid, core_ferr;
  logic [STATUS_W-1:0] status_q, status_d;
  logic [BYTE_W-1:0]   rx_byte_q;
  logic [FCNT_W-1:0]   frame_cnt_q;
  logic                unused_wdata;

  assign unused_wdata = ^bus.entrada_i[BUS_W-1:STATUS_W];

  uart_rx_core #(.CLK_PER_BIT(CLK_PER_BIT)) u_core (
    .clk    (clk),
    .rst    (rst),
    .rx     (rx),
    .byte_o (core_byte),
    .valid_o(core_valid),
    .ferr_o (core_ferr)
  );

  // Flag update: software write first, hardware sets override it.
  always_comb begin
    status_d = status_q;
    if (bus.wr_i && (bus.reg_sel_i == REG_CTRL)) status_d = bus.entrada_i[STATUS_W-1:0];
    if (core_valid) begin
      status_d[ST_NEW] = 1'b1;
      if (status_q[ST_NEW]) status_d[ST_OVR] = 1'b1;
    end
    if (core_ferr) status_d[ST_FERR] = 1'b1;
  end

  // Register bank.
  always_ff @(posedge clk) begin
    if (rst) begin
      status_q    <= '0;
      rx_byte_q   <= '0;
      frame_cnt_q <= '0;
    end else begin
      status_q <= status_d;
      if (core_valid) begin
        rx_byte_q   <= core_byte;
        frame_cnt_q <= frame_cnt_q + FCNT_W'(1);
      end
    end
  end

  // Read mux.
  always_comb begin
    bus.salida_o = '0;
    if (bus.reg_sel_i == REG_CTRL) begin
      bus.salida_o[STATUS_W-1:0] = status_q;
    end else if (bus.addr_i == ADDR_BYTE) begin
      bus.salida_o[BYTE_W-1:0] = rx_byte_q;
    end else begin
      bus.salida_o[FCNT_W-1:0] = frame_cnt_q;
    end
  end

endmodule
